vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
Vending sequencer placed after the currency validator. It accumulates validated coin pulses into a credit register and resolves product selections against a fixed price table. It hands one dispense request and then one change request to downstream actuators over valid/ack handshakes. Single clock, one transaction in flight.

Parameters:
CURRENCY_WIDTH, 7, width of coin values, credit, prices and change
PRICE_TABLE, {7'd25,7'd20,7'd15,7'd10}, 4 packed prices; product 0 at LSBs (0:10, 1:15, 2:20, 3:25)
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before automatic refund; minimum 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
currency_value  in  CURRENCY_WIDTH  value of validated coin
currency_valid  in  1  one-cycle pulse per validated coin
coin_ready  out  1  coins accepted (state IDLE or COLLECT)
coin_reject  out  1  one-cycle pulse: coin not credited, upstream returns it
sel_valid  in  1  one-cycle selection pulse
sel_id  in  2  selected product
sel_nack  out  1  one-cycle pulse: insufficient credit
cancel  in  1  one-cycle refund request
credit  out  CURRENCY_WIDTH  current credit
dispense_valid  out  1  dispense request, held until ack
dispense_id  out  2  product to dispense
dispense_ack  in  1  dispenser done
change_valid  out  1  change request, held until ack
change_value  out  CURRENCY_WIDTH  amount to return
change_ack  in  1  change paid
busy  out  1  state DISPENSE or CHANGE

Behaviour:
- Reset (async, rst=1): state IDLE; credit, dispense_id, change_value, timeout counter = 0. All pulses and valids = 0. Credit in flight is lost. coin_ready = 1 once in IDLE.
- Coin accepted in a cycle: coin_ready=1 and currency_valid=1 and currency_value!=0. Zero-value coin is ignored with no reject.
- Credit sum is CURRENCY_WIDTH+1 wide. If the sum exceeds 2^W-1, credit is unchanged and coin_reject pulses in the next cycle. There is no saturation or wrap.
- currency_valid while coin_ready=0 (DISPENSE/CHANGE): coin_reject pulses, credit unchanged.
- IDLE: an accepted coin sets credit=value and moves to COLLECT. sel_valid -> sel_nack. cancel ignored.
- COLLECT: evaluation order within a cycle:
  - coin is added first (eff = credit + coin);
  - then cancel, which has priority over sel;
  - then sel.
- COLLECT transitions:
  - cancel -> CHANGE, change_value = eff.
  - sel_valid with eff >= price[sel_id] -> latch dispense_id, credit = eff - price, go to DISPENSE.
  - sel_valid with eff < price -> sel_nack pulse, credit = eff, stay in COLLECT.
- Timeout counter resets on any coin, sel or cancel. Reaching TIMEOUT_CYCLES -> CHANGE with change_value = credit.
- DISPENSE: dispense_valid=1 from the cycle after entry, stable until the dispense_ack cycle.
  - On ack: credit>0 -> CHANGE (change_value = credit); else -> IDLE.
  - cancel ignored.
- CHANGE: change_valid=1, change_value stable until change_ack. On ack: credit=0, change_value=0, go to IDLE.
- Latency:
  - coin to credit update: 1 cycle;
  - sel to dispense_valid: 1 cycle;
  - ack to next state: 1 cycle;
  - ack arriving in the same cycle valid first rises is legal.
- dispense_ack/change_ack outside their state are ignored.
- sel_nack, coin_reject: registered, exactly one cycle wide.

Optional Feature:
SALES_COUNT_EN
- Defined: port sales_total out 16 is added. It resets to 0 and increments on each dispense_ack accepted in DISPENSE, wrapping 0xFFFF -> 0.
- Undefined: sales_total still exists but is tied to 0; no counter logic.

Test Plan:
- Reset, coins 5 then 10, sel_id=1 -> dispense_valid, dispense_id=1, credit=0. After dispense_ack -> IDLE with no change_valid.
- Coin 20, sel_id=0, dispense_ack -> change_valid with change_value=10. change_ack -> IDLE, credit=0.
- Coin 10, sel_id=3 -> sel_nack 1 cycle, credit 10. Then cancel -> change_value=10.
- Coin 100, coin 50 (W=7) -> coin_reject 1 cycle, credit stays 100. Coin in DISPENSE -> coin_reject.
- Coin 5, no activity for TIMEOUT_CYCLES -> change_valid with change_value=5. Same-cycle coin 10 + cancel from credit 5 -> change_value=15.
- rst asserted mid-DISPENSE -> all outputs 0 immediately, IDLE. With SALES_COUNT_EN: 3 completed dispenses -> sales_total=3, and reset -> 0.

Source files
------------

// File: rtl/vend_ctrl_if.sv
// rtl/vend_ctrl_if.sv - coin, selection, dispense and change signals of the vending sequencer
// slave is the sequencer side, master is the environment (validator, keypad, actuators).
interface vend_ctrl_if #(
  parameter int W = 7
);
  logic [W-1:0] currency_value;
  logic         currency_valid;
  logic         coin_ready;
  logic         coin_reject;
  logic         sel_valid;
  logic [1:0]   sel_id;
  logic         sel_nack;
  logic         cancel;
  logic [W-1:0] credit;
  logic         dispense_valid;
  logic [1:0]   dispense_id;
  logic         dispense_ack;
  logic         change_valid;
  logic [W-1:0] change_value;
  logic         change_ack;
  logic         busy;
  logic [15:0]  sales_total;

  modport slave (
    input  currency_value, currency_valid, sel_valid, sel_id, cancel,
           dispense_ack, change_ack,
    output coin_ready, coin_reject, sel_nack, credit, dispense_valid,
           dispense_id, change_valid, change_value, busy, sales_total
  );

  modport master (
    output currency_value, currency_valid, sel_valid, sel_id, cancel,
           dispense_ack, change_ack,
    input  coin_ready, coin_reject, sel_nack, credit, dispense_valid,
           dispense_id, change_valid, change_value, busy, sales_total
  );
endinterface

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending sequencer: coin credit, price check, dispense then change handshakes
// Define SALES_COUNT_EN to add the 16-bit completed-dispense counter on sales_total.
module vend_ctrl #(
  parameter int                          CURRENCY_WIDTH = 7,
  parameter logic [4*CURRENCY_WIDTH-1:0] PRICE_TABLE    = {7'd25, 7'd20, 7'd15, 7'd10},
  parameter int                          TIMEOUT_CYCLES = 1000
) (
  input logic        clk,
  input logic        rst,
  vend_ctrl_if.slave bus
);

  localparam int W  = CURRENCY_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_credit, w_credit_nxt;
  logic [W-1:0]   r_change_value, w_change_value_nxt;
  logic [1:0]     r_dispense_id, w_dispense_id_nxt;
  logic [TW-1:0]  r_tmo, w_tmo_nxt;
  logic           r_coin_reject, w_coin_reject_nxt;
  logic           r_sel_nack, w_sel_nack_nxt;

  logic           w_coin_ready;
  logic           w_coin_take;
  logic [W:0]     w_sum;
  logic           w_ovf;
  logic [W-1:0]   w_eff;
  logic [W-1:0]   w_price;
  logic           w_activity;

  assign w_coin_ready = (r_state == S_IDLE) || (r_state == S_COLLECT);
  assign w_coin_take  = w_coin_ready && bus.currency_valid && (bus.currency_value != '0);
  assign w_sum        = {1'b0, r_credit} + {1'b0, bus.currency_value};
  assign w_ovf        = w_sum[W];
  // Effective credit seen by cancel/selection: the coin of this cycle counts unless it overflows.
  assign w_eff        = (w_coin_take && !w_ovf) ? w_sum[W-1:0] : r_credit;
  assign w_price      = PRICE_TABLE[32'(bus.sel_id) * W +: W];
  assign w_activity   = bus.currency_valid || bus.sel_valid || bus.cancel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_change_value <= '0;
      r_dispense_id  <= '0;
      r_tmo          <= '0;
      r_coin_reject  <= 1'b0;
      r_sel_nack     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_change_value <= w_change_value_nxt;
      r_dispense_id  <= w_dispense_id_nxt;
      r_tmo          <= w_tmo_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_sel_nack     <= w_sel_nack_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_change_value_nxt = r_change_value;
    w_dispense_id_nxt  = r_dispense_id;
    w_tmo_nxt          = '0;
    w_sel_nack_nxt     = 1'b0;
    w_coin_reject_nxt  = bus.currency_valid &&
                         (!w_coin_ready || (r_state == S_COLLECT && w_coin_take && w_ovf));

    case (r_state)
      S_IDLE: begin
        if (bus.sel_valid) begin
          w_sel_nack_nxt = 1'b1;
        end
        if (w_coin_take) begin
          w_credit_nxt = bus.currency_value;
          w_state_nxt  = S_COLLECT;
        end
      end

      S_COLLECT: begin
        w_credit_nxt = w_eff;
        if (bus.cancel) begin
          w_change_value_nxt = w_eff;
          w_state_nxt        = S_CHANGE;
        end else if (bus.sel_valid && (w_eff >= w_price)) begin
          w_dispense_id_nxt = bus.sel_id;
          w_credit_nxt      = w_eff - w_price;
          w_state_nxt       = S_DISPENSE;
        end else if (bus.sel_valid) begin
          w_sel_nack_nxt = 1'b1;
        end else if (!w_activity) begin
          if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            w_change_value_nxt = r_credit;
            w_state_nxt        = S_CHANGE;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
        end
      end

      S_DISPENSE: begin
        if (bus.dispense_ack) begin
          if (r_credit != '0) begin
            w_change_value_nxt = r_credit;
            w_state_nxt        = S_CHANGE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_CHANGE: begin
        if (bus.change_ack) begin
          w_credit_nxt       = '0;
          w_change_value_nxt = '0;
          w_state_nxt        = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.coin_ready     = w_coin_ready;
  assign bus.coin_reject    = r_coin_reject;
  assign bus.sel_nack       = r_sel_nack;
  assign bus.credit         = r_credit;
  assign bus.dispense_valid = (r_state == S_DISPENSE);
  assign bus.dispense_id    = r_dispense_id;
  assign bus.change_valid   = (r_state == S_CHANGE);
  assign bus.change_value   = r_change_value;
  assign bus.busy           = (r_state == S_DISPENSE) || (r_state == S_CHANGE);

`ifdef SALES_COUNT_EN
  logic [15:0] r_sales_total;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sales_total <= '0;
    end else if (r_state == S_DISPENSE && bus.dispense_ack) begin
      r_sales_total <= r_sales_total + 16'd1;
    end
  end

  assign bus.sales_total = r_sales_total;
`else
  assign bus.sales_total = '0;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed and random checks of vend_ctrl against a transaction-level model
module tb_vend_ctrl;
  localparam int TMO = 20;
  localparam int MAXC = 127;

  localparam int M_IDLE = 0;
  localparam int M_COLLECT = 1;
  localparam int M_DISPENSE = 2;
  localparam int M_CHANGE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       cv = 1'b0;
  logic [6:0] cval = '0;
  logic       sv = 1'b0;
  logic [1:0] sid = '0;
  logic       cc = 1'b0;
  logic       dack = 1'b0;
  logic       cack = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  int price[4] = '{10, 15, 20, 25};
  int coin_menu[8] = '{0, 5, 10, 20, 25, 50, 100, 127};

  int m_state, m_credit, m_change, m_did, m_idle;
  bit m_reject, m_nack;
  logic [15:0] m_sales;

  vend_ctrl_if #(.W(7)) bus ();

  assign bus.currency_valid = cv;
  assign bus.currency_value = cval;
  assign bus.sel_valid      = sv;
  assign bus.sel_id         = sid;
  assign bus.cancel         = cc;
  assign bus.dispense_ack   = dack;
  assign bus.change_ack     = cack;

  vend_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_credit = 0;
    m_change = 0;
    m_did = 0;
    m_idle = 0;
    m_reject = 0;
    m_nack = 0;
    m_sales = '0;
  endtask

  task automatic model_step();
    int coin;
    int eff;
    bit ready;
    ready = (m_state == M_IDLE) || (m_state == M_COLLECT);
    coin = cv ? int'(cval) : 0;
    m_reject = cv && !ready;
    m_nack = 0;
    case (m_state)
      M_IDLE: begin
        if (sv) m_nack = 1;
        if (coin != 0) begin
          m_credit = coin;
          m_idle = 0;
          m_state = M_COLLECT;
        end
      end
      M_COLLECT: begin
        eff = m_credit;
        if (coin != 0) begin
          if (m_credit + coin > MAXC) m_reject = 1;
          else eff = m_credit + coin;
        end
        if (cv || sv || cc) m_idle = 0;
        else m_idle++;
        if (cc) begin
          m_credit = eff;
          m_change = eff;
          m_state = M_CHANGE;
        end else if (sv && eff >= price[sid]) begin
          m_did = int'(sid);
          m_credit = eff - price[sid];
          m_state = M_DISPENSE;
        end else begin
          if (sv) m_nack = 1;
          m_credit = eff;
          if (m_idle == TMO) begin
            m_change = m_credit;
            m_state = M_CHANGE;
          end
        end
      end
      M_DISPENSE: begin
        if (dack) begin
          m_sales = m_sales + 16'd1;
          if (m_credit > 0) begin
            m_change = m_credit;
            m_state = M_CHANGE;
          end else begin
            m_state = M_IDLE;
          end
        end
      end
      default: begin
        if (cack) begin
          m_credit = 0;
          m_change = 0;
          m_state = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("coin_ready", bus.coin_ready, (m_state == M_IDLE || m_state == M_COLLECT));
    chk("coin_reject", bus.coin_reject, m_reject);
    chk("sel_nack", bus.sel_nack, m_nack);
    chk("credit", bus.credit, m_credit);
    chk("dispense_valid", bus.dispense_valid, (m_state == M_DISPENSE));
    chk("dispense_id", bus.dispense_id, m_did);
    chk("change_valid", bus.change_valid, (m_state == M_CHANGE));
    chk("change_value", bus.change_value, m_change);
    chk("busy", bus.busy, (m_state == M_DISPENSE || m_state == M_CHANGE));
`ifdef SALES_COUNT_EN
    chk("sales_total", bus.sales_total, m_sales);
`else
    chk("sales_total", bus.sales_total, 0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic step(input bit a_cv, input int a_val, input bit a_sv, input int a_sid,
                      input bit a_cc, input bit a_da, input bit a_ca);
    cv = a_cv;
    cval = 7'(a_val);
    sv = a_sv;
    sid = 2'(a_sid);
    cc = a_cc;
    dack = a_da;
    cack = a_ca;
    cycle();
    cv = 0;
    sv = 0;
    cc = 0;
    dack = 0;
    cack = 0;
  endtask

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
    chk("reset_coin_ready", bus.coin_ready, 1);

    // coins 5 + 10, buy product 1 exactly
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 10, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    chk("t1_dispense_valid", bus.dispense_valid, 1);
    chk("t1_dispense_id", bus.dispense_id, 1);
    chk("t1_credit", bus.credit, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t1_no_change", bus.change_valid, 0);
    chk("t1_idle", bus.busy, 0);

    // coin 20, product 0 leaves 10 change
    step(1, 20, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t2_change_valid", bus.change_valid, 1);
    chk("t2_change_value", bus.change_value, 10);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t2_credit", bus.credit, 0);
    chk("t2_idle", bus.busy, 0);

    // insufficient credit then cancel
    step(1, 10, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    chk("t3_nack", bus.sel_nack, 1);
    chk("t3_credit", bus.credit, 10);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_nack_width", bus.sel_nack, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t3_change_value", bus.change_value, 10);
    step(0, 0, 0, 0, 0, 0, 1);

    // overflow reject, then reject while dispensing
    step(1, 100, 0, 0, 0, 0, 0);
    step(1, 50, 0, 0, 0, 0, 0);
    chk("t4_reject", bus.coin_reject, 1);
    chk("t4_credit", bus.credit, 100);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t4_reject_width", bus.coin_reject, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    chk("t4_reject_busy", bus.coin_reject, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_change_value", bus.change_value, 75);
    step(0, 0, 0, 0, 0, 0, 1);

    // timeout refund boundary
    step(1, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_not_yet", bus.change_valid, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_timeout", bus.change_valid, 1);
    chk("t5_timeout_value", bus.change_value, 5);
    step(0, 0, 0, 0, 0, 0, 1);

    // same-cycle coin and cancel
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 10, 0, 0, 1, 0, 0);
    chk("t5_coin_cancel", bus.change_value, 15);
    step(0, 0, 0, 0, 0, 0, 1);

    // reset in the middle of a dispense
    step(1, 25, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    chk("t6_dispensing", bus.dispense_valid, 1);
`ifdef SALES_COUNT_EN
    chk("t6_sales", bus.sales_total, 3);
`endif
    rst = 1'b1;
    #1;
    chk("t6_rst_dispense_valid", bus.dispense_valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_credit", bus.credit, 0);
    chk("t6_rst_sales", bus.sales_total, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // random traffic against the model, with periodic quiet windows to hit timeouts
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if ((i % 250) >= 220) begin
        step(0, 0, 0, 0, 0, r < 50, r >= 50);
      end else begin
        step($urandom_range(0, 99) < 25, coin_menu[$urandom_range(0, 7)],
             $urandom_range(0, 99) < 12, $urandom_range(0, 3),
             $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
